control_export: RTL and testbench

CONTROL_EXPORT -- requirements
Module: control_export

---
 rtl/control_export.sv | 147 ++++++++++++++
 tb/tb_control_export.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_export.sv
// rtl/control_export.sv - streams DEPTH words from a result memory through a 2-entry FIFO
//
// Purpose:
//   On start, reads addresses 0..DEPTH-1 from a memory with one cycle of read latency.
//   Each word is buffered in a 2-entry FIFO and presented on a valid/ready output port
//   in address order. Reads are only issued when the FIFO has room for them.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a run (accepted only in IDLE)
//   rd_en      memory read strobe
//   rd_addr    memory read address
//   rd_data    memory read data, valid the cycle after rd_en
//   out_valid  out_data holds a word
//   out_ready  downstream accepts the word
//   out_data   exported word (0 while the FIFO is empty)
//   busy       run in progress (READ, DRAIN or FIN)
//   done       one-cycle pulse at the end of a run

module control_export #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              in_flight;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] xfer_cnt;

  logic              push;
  logic              pop;
  logic [1:0]        committed;
  logic              last_read;
  logic              last_xfer;
  logic              run_start;

  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign rd_addr   = addr;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  assign push      = in_flight;
  assign pop       = out_valid && out_ready;

  // Slots that will be occupied once this cycle's pop leaves and the in-flight word
  // lands. Counting the pop lets a read issue every cycle while the output streams,
  // and still guarantees the word from a read issued now always has a slot.
  assign committed = count + {1'b0, in_flight} - {1'b0, pop};
  assign rd_en     = (state == READ) && (committed < 2'd2);

  assign last_read = rd_en && (addr == LAST);
  assign last_xfer = pop && (xfer_cnt == LAST);
  assign run_start = (state == IDLE) && start;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = READ;
      READ:    if (last_read) state_nxt = DRAIN;
      DRAIN:   if (last_xfer) state_nxt = FIN;
      FIN:                    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read address and transfer counter; both restart at 0 on each run and never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      xfer_cnt <= '0;
    end else begin
      if (run_start) begin
        addr <= '0;
      end else if (rd_en && !last_read) begin
        addr <= addr + ADDR_W'(1);
      end

      if (run_start) begin
        xfer_cnt <= '0;
      end else if (pop && !last_xfer) begin
        xfer_cnt <= xfer_cnt + ADDR_W'(1);
      end
    end
  end

  // Pointer/occupancy state. Clearing in_flight on reset drops any read still in
  // flight, so its data never enters the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      in_flight <= rd_en;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: out_data is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= rd_data;
    end
  end

endmodule

// File: tb/tb_control_export.sv
// tb/tb_control_export.sv - self-checking bench for control_export

module tb_control_export;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [DEPTH];

  control_export #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Memory with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted run must deliver mem[0..DEPTH-1] in order,
  // read addresses must go 0,1,2,... and no more than 2 words may ever be read
  // but not yet delivered.
  logic [7:0] exp_q [$];
  int         mon_issued = 0;
  int         mon_xfer   = 0;
  int         done_cnt   = 0;
  bit         stall_prev = 0;
  logic [7:0] stall_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mon_issued = 0;
      mon_xfer   = 0;
      stall_prev = 0;
    end else begin
      if (start && !busy) begin
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem[i]);
        mon_issued = 0;
        mon_xfer   = 0;
      end
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, stall_data);
      end
      if (rd_en) begin
        check("rd_addr_order", rd_addr, mon_issued);
        mon_issued++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          check("word_order", out_data, exp_q.pop_front());
        end
        mon_xfer++;
      end
      if (rd_en) check("credit_outstanding_le2", (mon_issued - mon_xfer) <= 2, 1);
      if (done) begin
        done_cnt++;
        check("run_words", mon_xfer, DEPTH);
        check("run_queue_empty", exp_q.size(), 0);
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready held high; 1: random ready; 2: random ready and start held while busy
  task automatic run_until_done(input int mode, input int bound, input string name);
    bit seen = 0;
    int n = 0;
    while (!seen && n < bound) begin
      out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start     = (mode == 2) ? busy : 1'b0;
      #1;
      if (done) seen = 1;
      step();
      n++;
    end
    start = 1'b0;
    check({name, "_done_seen"}, seen, 1);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_rd_en"}, rd_en, 0);
    check({name, "_rd_addr"}, rd_addr, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
  endtask

  typedef struct {
    logic       start;
    logic       ready;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic       out_valid;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [22];

  initial begin
    int d0;
    int c;
    logic [7:0] held;

    // Cycle-by-cycle expectations for a run with ready held high, followed by a
    // restart in the cycle after done (cycle 20).
    for (int i = 0; i < 22; i++) begin
      tbl[i].start     = (i == 0 || i == 20);
      tbl[i].ready     = 1'b1;
      tbl[i].rd_en     = (i >= 1 && i <= 16) || (i == 21);
      tbl[i].rd_addr   = (i == 0 || i == 21) ? 4'd0 : (i <= 16) ? 4'(i - 1) : 4'd15;
      tbl[i].out_valid = (i >= 3 && i <= 18);
      tbl[i].out_data  = (i >= 3 && i <= 18) ? 8'(8'hA0 + i - 3) : 8'h00;
      tbl[i].busy      = (i >= 1 && i <= 19) || (i == 21);
      tbl[i].done      = (i == 19);
    end
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'hA0 + i);

    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    #2;
    check_zero_outputs("reset");
    step();
    step();
    rst = 1'b0;
    step();

    // Minimum-latency run and back-to-back restart.
    d0 = done_cnt;
    for (int i = 0; i < 22; i++) begin
      start = tbl[i].start;
      out_ready = tbl[i].ready;
      #1;
      check("tbl_rd_en", rd_en, tbl[i].rd_en);
      check("tbl_rd_addr", rd_addr, tbl[i].rd_addr);
      check("tbl_out_valid", out_valid, tbl[i].out_valid);
      check("tbl_out_data", out_data, tbl[i].out_data);
      check("tbl_busy", busy, tbl[i].busy);
      check("tbl_done", done, tbl[i].done);
      step();
    end
    start = 1'b0;
    run_until_done(0, 40, "restart");
    check("restart_done_count", done_cnt - d0, 2);

    // Output stalled for 10 cycles mid-run.
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    out_ready = 1'b0;
    #1;
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_data", out_data, held);
    end
    check("stall_rd_en_off", rd_en, 0);
    check("stall_out_valid", out_valid, 1);
    d0 = done_cnt;
    run_until_done(0, 40, "stall");
    check("stall_done_count", done_cnt - d0, 1);

    // Random memory contents, random ready.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      start = 1'b1;
      step();
      start = 1'b0;
      d0 = done_cnt;
      run_until_done(1, 200, "random");
      check("random_done_count", done_cnt - d0, 1);
    end

    // start held while busy, including the FIN cycle.
    start = 1'b1;
    step();
    d0 = done_cnt;
    run_until_done(2, 200, "start_spam");
    for (int i = 0; i < 3; i++) begin
      #1;
      check("start_spam_idle_busy", busy, 0);
      step();
    end
    check("start_spam_done_count", done_cnt - d0, 1);

    // Reset after 5 transfers.
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'hA0 + i);
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (mon_xfer < 5 && c < 30) begin
      step();
      c++;
    end
    check("abort_reached_5", mon_xfer, 5);
    d0 = done_cnt;
    #1;
    rst = 1'b1;
    #1;
    check_zero_outputs("abort");
    step();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) step();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle_valid", out_valid, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("fresh_rd_addr", rd_addr, 0);
    check("fresh_rd_en", rd_en, 1);
    step();
    step();
    check("fresh_first_word", out_data, 8'hA0);
    run_until_done(0, 40, "fresh");
    check("fresh_done_count", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
